// File: rtl/hop_fmod_gen.sv
// rtl/hop_fmod_gen.sv - bit-serial F = 16*CLK[27:7] mod 79 and F' = 32*CLK[27:7] mod N feeder
// Optional HOP_FMOD_PIPE2_EN: two reduction steps per cycle (13-cycle latency instead of 26).
module hop_fmod_gen #(
  parameter int CLKW = 21,
  parameter int MODF = 79
) (
  input  logic            clk,
  input  logic            rstz,
  input  logic            start,
  input  logic [CLKW-1:0] clk27_7,
  input  logic [6:0]      regi_AFH_modN,
  output logic [6:0]      F,
  output logic [6:0]      Fprime,
  output logic            busy,
  output logic            done,
  output logic            modn_err
);
  localparam int SRW = CLKW + 5;
`ifdef HOP_FMOD_PIPE2_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 1;
`endif
  localparam int CNT_LOAD = SRW / STEPS;
  localparam int CW = $clog2(CNT_LOAD + 1);
  localparam logic [6:0] MOD_F = 7'(MODF);

  logic [SRW-1:0] sr, sr_nxt;
  logic [6:0]     nq, rf, rn, rf_nxt, rn_nxt;
  logic           lag, lag_nxt;
  logic [CW-1:0]  count;

  // One restoring step: t = 2r + b never exceeds 2M-1 while r < M.
  function automatic logic [6:0] mod_step(input logic [6:0] r, input logic b, input logic [6:0] m);
    logic [7:0] t;
    t = {r, b};
    if (t >= {1'b0, m}) return 7'(t - {1'b0, m});
    return t[6:0];
  endfunction

  // The F stream is the N stream delayed by one bit, so lag carries the previous N bit.
  always_comb begin
    rf_nxt  = rf;
    rn_nxt  = rn;
    sr_nxt  = sr;
    lag_nxt = lag;
    for (int s = 0; s < STEPS; s++) begin
      rf_nxt  = mod_step(rf_nxt, lag_nxt, MOD_F);
      rn_nxt  = modn_err ? 7'd0 : mod_step(rn_nxt, sr_nxt[SRW-1], nq);
      lag_nxt = sr_nxt[SRW-1];
      sr_nxt  = {sr_nxt[SRW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstz) begin
      F        <= '0;
      Fprime   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      modn_err <= 1'b0;
      count    <= '0;
      rf       <= '0;
      rn       <= '0;
      sr       <= '0;
      nq       <= '0;
      lag      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr       <= {clk27_7, 5'b0};
        nq       <= regi_AFH_modN;
        rf       <= '0;
        rn       <= '0;
        lag      <= 1'b0;
        count    <= CW'(CNT_LOAD);
        busy     <= 1'b1;
        modn_err <= (regi_AFH_modN < 7'd20) || (regi_AFH_modN > 7'd79);
      end else if (busy) begin
        sr    <= sr_nxt;
        rf    <= rf_nxt;
        rn    <= rn_nxt;
        lag   <= lag_nxt;
        count <= count - 1'b1;
        if (count == CW'(1)) begin
          F      <= rf_nxt;
          Fprime <= rn_nxt;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end
endmodule
